rf_link_core_mc: RTL

- Parametrised, multi-channel successor to the single-node RF transceiver datapath.
- Sits between the MCU-side UART byte stream and NUM_CH node-side UART byte streams; all UART engines are outside this block.
- Owns M0/M1 mode synchronisation, power-on and mode-switch hold-off, AUX generation, and a burst-buffered TX path with optional wake-up preamble.
- Owns a round-robin merged RX path from all node channels to the MCU.

---
 rtl/rf_link_core_mc.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rf_link_core_mc.sv
// rf_link_core_mc: multi-channel RF link datapath between an MCU UART byte
// stream and NUM_CH node UART byte streams.
//   - M0/M1 synchronisation, power-on and mode-switch hold-off, AUX output
//   - TX: circular burst buffer, threshold / idle-timeout burst start,
//     optional wake-up preamble in mode 1, one-hot node_tx_valid
//   - RX: round-robin merge of node channels into a 1-entry MCU register
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   M0, M1                 asynchronous mode pins
//   ch_sel                 destination channel, latched at burst start
//   mcu_rx_*               bytes from the MCU (valid/ready)
//   mcu_tx_*               bytes to the MCU (valid/ready)
//   node_tx_*              shared byte bus to nodes, one-hot valid
//   node_rx_*              packed per-channel bytes from nodes
//   mode                   applied mode {M1,M0}
//   aux                    1 = block idle/ready
module rf_link_core_mc #(
    parameter int DATA_WIDTH         = 8,
    parameter int NUM_CH             = 4,
    parameter int BUF_DEPTH          = 512,
    parameter int START_THRESHOLD    = 58,
    parameter int IDLE_TIMEOUT       = 651,
    parameter int WAKE_PREAMBLE_LEN  = 4,
    parameter logic [DATA_WIDTH-1:0] WAKE_BYTE = {DATA_WIDTH{1'b1}},
    parameter int POWER_ON_CYCLES    = 750000,
    parameter int MODE_SWITCH_CYCLES = 15000
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      M0,
    input  logic                                      M1,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
    input  logic [DATA_WIDTH-1:0]                     mcu_rx_data,
    input  logic                                      mcu_rx_valid,
    output logic                                      mcu_rx_ready,
    output logic [DATA_WIDTH-1:0]                     mcu_tx_data,
    output logic                                      mcu_tx_valid,
    input  logic                                      mcu_tx_ready,
    output logic [DATA_WIDTH-1:0]                     node_tx_data,
    output logic [NUM_CH-1:0]                         node_tx_valid,
    input  logic [NUM_CH-1:0]                         node_tx_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]              node_rx_data,
    input  logic [NUM_CH-1:0]                         node_rx_valid,
    output logic [NUM_CH-1:0]                         node_rx_ready,
    output logic [1:0]                                mode,
    output logic                                      aux
);

    localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW   = $clog2(BUF_DEPTH);
    localparam int CW   = $clog2(BUF_DEPTH + 1);
    localparam int TW   = $clog2(IDLE_TIMEOUT + 1);
    localparam int PCW  = $clog2(POWER_ON_CYCLES + 1);
    localparam int SWW  = $clog2(MODE_SWITCH_CYCLES + 1);
    localparam int PRW  = (WAKE_PREAMBLE_LEN > 1) ? $clog2(WAKE_PREAMBLE_LEN + 1) : 1;

    localparam logic [CW-1:0] START_TH = CW'(START_THRESHOLD);
    localparam logic [TW-1:0] TIMEOUT  = TW'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_PREAMBLE,
        TX_BURST
    } tx_state_t;

    tx_state_t              state, state_nx;

    logic [1:0]             m_meta, m_sync;
    logic [PCW-1:0]         po_cnt;
    logic                   po_done;
    logic [SWW-1:0]         sw_cnt;
    logic                   sw_done, mode_pend;
    logic                   paths_on, tx_on;

    logic [DATA_WIDTH-1:0]  mem [BUF_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic                   wr_en, rd_en, tx_hs;
    logic [TW-1:0]          idle_tmr;

    logic                   start, burst_end;
    logic [CHW-1:0]         ch_lat;
    logic [CW-1:0]          burst_rem;
    logic [PRW-1:0]         pre_cnt;

    logic [CHW-1:0]         rr_ptr, gnt;
    logic                   found, rx_load;

    assign sw_done   = (sw_cnt == '0);
    assign mode_pend = (m_sync != mode);
    assign paths_on  = po_done && sw_done && (mode != 2'd3);
    assign tx_on     = paths_on && !mode[1];

    assign mcu_rx_ready = tx_on && (count < CW'(BUF_DEPTH));
    assign wr_en        = mcu_rx_valid && mcu_rx_ready;
    assign tx_hs        = |(node_tx_valid & node_tx_ready);
    assign rd_en        = (state == TX_BURST) && tx_hs;
    assign rx_load      = paths_on && (!mcu_tx_valid || mcu_tx_ready);

    // A burst never starts while a mode change is pending, so the preamble
    // decision always uses the mode that will be in force for the burst.
    always_comb begin
        state_nx      = state;
        node_tx_valid = '0;
        node_tx_data  = '0;
        start         = 1'b0;
        burst_end     = 1'b0;
        case (state)
            TX_IDLE: begin
                if (tx_on && !mode_pend && (count != '0) &&
                    ((count >= START_TH) || (idle_tmr == TIMEOUT))) begin
                    start    = 1'b1;
                    state_nx = ((mode == 2'd1) && (WAKE_PREAMBLE_LEN > 0)) ? TX_PREAMBLE : TX_BURST;
                end
            end
            TX_PREAMBLE: begin
                node_tx_valid[ch_lat] = 1'b1;
                node_tx_data          = WAKE_BYTE;
                if (tx_hs && (pre_cnt == PRW'(WAKE_PREAMBLE_LEN - 1)))
                    state_nx = TX_BURST;
            end
            TX_BURST: begin
                node_tx_valid[ch_lat] = 1'b1;
                node_tx_data          = mem[rd_ptr];
                if (tx_hs && (burst_rem == CW'(1))) begin
                    state_nx  = TX_IDLE;
                    burst_end = 1'b1;
                end
            end
            default: state_nx = TX_IDLE;
        endcase
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        int unsigned idx;
        found         = 1'b0;
        gnt           = '0;
        node_rx_ready = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_CH)
                idx = idx - NUM_CH;
            if (!found && node_rx_valid[idx]) begin
                found = 1'b1;
                gnt   = CHW'(idx);
            end
        end
        if (rx_load && found)
            node_rx_ready[gnt] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= TX_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= mcu_rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_meta       <= '0;
            m_sync       <= '0;
            po_cnt       <= '0;
            po_done      <= 1'b0;
            sw_cnt       <= '0;
            mode         <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            idle_tmr     <= '0;
            ch_lat       <= '0;
            burst_rem    <= '0;
            pre_cnt      <= '0;
            rr_ptr       <= '0;
            mcu_tx_data  <= '0;
            mcu_tx_valid <= 1'b0;
            aux          <= 1'b0;
        end else begin
            m_meta <= {M1, M0};
            m_sync <= m_meta;

            // Mode control: power-on hold, then changes accepted only in TX_IDLE.
            if (!po_done) begin
                if (po_cnt == PCW'(POWER_ON_CYCLES - 1)) begin
                    po_done <= 1'b1;
                    mode    <= m_sync;
                end else begin
                    po_cnt <= po_cnt + 1'b1;
                end
            end else if (mode_pend && (state == TX_IDLE)) begin
                mode   <= m_sync;
                sw_cnt <= SWW'(MODE_SWITCH_CYCLES);
            end else if (!sw_done) begin
                sw_cnt <= sw_cnt - 1'b1;
            end

            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (wr_en || burst_end)
                idle_tmr <= '0;
            else if ((count != '0) && (idle_tmr != TIMEOUT))
                idle_tmr <= idle_tmr + 1'b1;

            if (start) begin
                ch_lat    <= ch_sel;
                burst_rem <= count;
                pre_cnt   <= '0;
            end else if (tx_hs && (state == TX_PREAMBLE)) begin
                pre_cnt <= pre_cnt + 1'b1;
            end else if (rd_en) begin
                burst_rem <= burst_rem - 1'b1;
            end

            if (rx_load && found) begin
                mcu_tx_data  <= node_rx_data[gnt*DATA_WIDTH +: DATA_WIDTH];
                mcu_tx_valid <= 1'b1;
                rr_ptr       <= gnt;
            end else if (mcu_tx_ready) begin
                mcu_tx_valid <= 1'b0;
            end

            aux <= po_done && sw_done && !mode_pend && (state == TX_IDLE) &&
                   (count == '0) && !mcu_tx_valid;
        end
    end

endmodule
